data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Memory-side responder for the MIPS pipeline's data-memory interface: it serves the memory stage's load/store requests against an internal byte-enabled word array. It accepts one request per handshake, performs the access after a configurable wait, and returns the read word with a one-cycle response pulse. It replaces a fixed single-cycle RAM macro wherever the pipeline must tolerate multi-cycle memory and stall on `ready`.

## Interface
- `B`, 32, data and address width
- `W`, 10, word-index width; the array holds 2^W words
- `LAT`, 1, extra wait cycles per access, 0..7

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `req`  in  1  request valid
- `ready`  out  1  responder can accept; transfer when `req && ready` at a rising edge
- `addr_in`  in  B  byte address; word index = `addr_in[W+1:2]`; bits above W+1 ignored
- `write_data`  in  B  store data, byte lane i = bits 8i+7:8i
- `we`  in  4  byte-lane write enables; 4'b0000 = load
- `data_out`  out  B  word read at the accessed index, held until next response
- `resp_valid`  out  1  one-cycle pulse, response available
- `resp_err`  out  1  qualifies `resp_valid`: misaligned request

## Operation
- States: IDLE, WAIT, RESP (+ CLEAR with macro).
- IDLE: `ready`=1. On accept, capture `addr_in`, `write_data`, `we`. If LAT=0, go to RESP; else load counter with LAT and go to WAIT.
- WAIT: `ready`=0. Decrement the counter each cycle. At count 1, go to RESP.
- The array access (read, plus masked write if `we`≠0) happens on the edge entering RESP. The access is read-first: `data_out` returns the pre-write word.
- RESP: `resp_valid`=1 and `ready`=0 for exactly one cycle, then IDLE.
- Misaligned request (`addr_in[1:0]`≠0, any `we`): no array write; `data_out`=0 and `resp_err`=1 in RESP. Latency is unchanged.
- `req` while `ready`=0 is ignored. Requesters hold `req` and inputs until accepted.
- Inputs are sampled only at acceptance. Changes during WAIT have no effect.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, `ready`=0 while `rst_n` is low, `data_out`=0, `resp_valid`=0, `resp_err`=0, counter=0.
- First cycle after `rst_n` rises: `ready`=1 (without the macro).
- Accept in cycle n gives `resp_valid` in cycle n+1+LAT.
- Minimum spacing between accepts is LAT+2 cycles.
- Reset during WAIT abandons the access. Array contents are untouched and no write commits. Reset in the same cycle as an accept discards the request.
- `resp_err` and `resp_valid` deassert the cycle after RESP. `data_out` holds its value.

## Configuration
- `DMEM_CLEAR_ON_RESET_EN` defined: after `rst_n` rises, enter CLEAR.
  - Write zero to words 0..2^W−1, one per cycle, with `ready`=0.
  - Enter IDLE after the last word, so `ready` rises 2^W cycles after reset release.
  - Reset during CLEAR restarts from word 0.
- Not defined: no CLEAR state. Contents are uninitialized at power-up and retained across reset.

## Structure
- Shared package `dmem_pkg`:
  - state encoding localparams (IDLE, WAIT, RESP, CLEAR)
  - `LAT_MAX`=7
  - counter width 3
- Sub-module `dmem_array`: single-port, read-first, 4-lane byte-write RAM of 2^W×B. Its ports are `clk`, `en`, `we[3:0]`, `idx[W-1:0]`, `din`, `dout`. The FSM and handshake stay in the top.

## Test plan
- LAT=1: store `we`=4'hF, addr 0x10, data 0xDEADBEEF, then load 0x10. Store response: `resp_valid` in cycle n+2, data_out = old word. Load: data_out=0xDEADBEEF, `resp_err`=0.
- Byte-lane write `we`=4'b0010, data 0x0000AB00 to 0x10, then load 0x10: 0xDEADABEF.
- Misaligned load addr 0x13: `resp_err`=1 with `resp_valid`, data_out=0. A follow-up load of 0x10 still returns 0xDEADABEF.
- Back-to-back requests with `req` held high, LAT=3: accepts spaced exactly 5 cycles apart, `ready` low between them, one `resp_valid` per accept.
- Store accepted, then `rst_n`=0 during WAIT (LAT=3): no `resp_valid`. The later load returns the pre-store word (without macro).
- With `DMEM_CLEAR_ON_RESET_EN`, W=4: `ready` stays 0 for 16 cycles after reset release, and a load of any address then returns 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: state encoding, wait-counter
// sizing and small address helpers.
package dmem_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
  localparam logic [1:0] ST_CLEAR = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_WAIT  = ST_WAIT,
    S_RESP  = ST_RESP,
    S_CLEAR = ST_CLEAR
  } state_t;

  localparam int LAT_MAX = 7;
  localparam int CNT_W   = 3;

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic logic is_misaligned(input logic [1:0] byte_off);
    return byte_off != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port, read-first word RAM with four byte-lane write enables.
// dout updates only on enabled cycles and otherwise keeps the last read word.
module dmem_array #(
  parameter int B = 32,
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         en,
  input  logic [3:0]   we,
  input  logic [W-1:0] idx,
  input  logic [B-1:0] din,
  output logic [B-1:0] dout
);

  localparam int LANE = B / 4;

  logic [B-1:0] mem [2**W];

  // NOTE: the array and its read register carry no reset so the storage maps onto
  // a RAM macro; a reset here would force flops and could never clear it in one cycle.
  always_ff @(posedge clk) begin
    if (en) begin
      dout <= mem[idx];
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[idx][LANE*i +: LANE] <= din[LANE*i +: LANE];
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: req/ready accept, LAT wait cycles, one-cycle
// response pulse. Define DMEM_CLEAR_ON_RESET_EN to zero the array after every reset.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int B   = 32,
  parameter int W   = 10,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req,
  output logic         ready,
  input  logic [B-1:0] addr_in,
  input  logic [B-1:0] write_data,
  input  logic [3:0]   we,
  output logic [B-1:0] data_out,
  output logic         resp_valid,
  output logic         resp_err
);

  localparam cnt_t LAT_CNT = cnt_t'(LAT);

  state_t       state, state_nx;
  cnt_t         cnt;
  logic [W+1:0] addr_q;
  logic [B-1:0] wdata_q;
  logic [3:0]   we_q;
  logic         err_q;
  logic [B-1:0] hold_q;

  logic         accept;
  logic         ram_en;
  logic [3:0]   ram_we;
  logic [W-1:0] ram_idx;
  logic [B-1:0] ram_din;
  logic [B-1:0] ram_dout;

  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_in[B-1:W+2];

`ifdef DMEM_CLEAR_ON_RESET_EN
  logic [W-1:0] clr_idx;
`endif

  assign accept = req && ready;

  // NOTE: every output of this block gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    ram_en   = 1'b0;
    ram_we   = 4'b0000;
    ram_idx  = addr_q[W+1:2];
    ram_din  = wdata_q;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (LAT == 0) begin
            // With no wait the access uses the live inputs on the accepting edge.
            state_nx = S_RESP;
            ram_en   = 1'b1;
            ram_idx  = addr_in[W+1:2];
            ram_din  = write_data;
            ram_we   = is_misaligned(addr_in[1:0]) ? 4'b0000 : we;
          end else begin
            state_nx = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == cnt_t'(1)) begin
          state_nx = S_RESP;
          ram_en   = 1'b1;
          ram_we   = err_q ? 4'b0000 : we_q;
        end
      end
      S_RESP: state_nx = S_IDLE;
`ifdef DMEM_CLEAR_ON_RESET_EN
      S_CLEAR: begin
        ram_en  = 1'b1;
        ram_we  = 4'hF;
        ram_idx = clr_idx;
        ram_din = '0;
        if (&clr_idx) state_nx = S_IDLE;
      end
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
      // Parking in CLEAR keeps ready low in reset and starts the sweep at release.
      state   <= S_CLEAR;
      clr_idx <= '0;
`else
      state   <= S_IDLE;
`endif
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= '0;
      err_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        addr_q  <= addr_in[W+1:0];
        wdata_q <= write_data;
        we_q    <= we;
        err_q   <= is_misaligned(addr_in[1:0]);
        cnt     <= LAT_CNT;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 1'b1;
      end
      if (state == S_RESP) hold_q <= data_out;
`ifdef DMEM_CLEAR_ON_RESET_EN
      if (state == S_CLEAR) clr_idx <= clr_idx + 1'b1;
`endif
    end
  end

  // Gating with rst_n drops an access whose commit edge coincides with reset.
  dmem_array #(.B(B), .W(W)) u_array (
    .clk  (clk),
    .en   (ram_en && rst_n),
    .we   (ram_we),
    .idx  (ram_idx),
    .din  (ram_din),
    .dout (ram_dout)
  );

  assign ready      = (state == S_IDLE) && rst_n;
  assign resp_valid = (state == S_RESP);
  assign resp_err   = (state == S_RESP) && err_q;
  assign data_out   = (state == S_RESP) ? (err_q ? '0 : ram_dout) : hold_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: two responders (LAT=1 and LAT=3, 16 words) driven by directed
// and random requests; a monitor checks every response against a word-array model.
module tb_data_mem_responder;

  localparam int TW = 4;
  localparam int NW = 16;
`ifdef DMEM_CLEAR_ON_RESET_EN
  localparam int CLR_CYC = NW;
`else
  localparam int CLR_CYC = 0;
`endif

  typedef struct {
    logic [31:0] data;
    logic        err;
    bit          known;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst_n      [2];
  logic        req        [2];
  logic        ready      [2];
  logic [31:0] addr       [2];
  logic [31:0] wdata      [2];
  logic [3:0]  we         [2];
  logic [31:0] data_out   [2];
  logic        resp_valid [2];
  logic        resp_err   [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] mem_m   [2][NW];
  bit          known_m [2][NW];
  exp_t        sb0[$];
  exp_t        sb1[$];

  data_mem_responder #(.B(32), .W(TW), .LAT(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req(req[0]), .ready(ready[0]), .addr_in(addr[0]),
    .write_data(wdata[0]), .we(we[0]), .data_out(data_out[0]),
    .resp_valid(resp_valid[0]), .resp_err(resp_err[0]));

  data_mem_responder #(.B(32), .W(TW), .LAT(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .req(req[1]), .ready(ready[1]), .addr_in(addr[1]),
    .write_data(wdata[1]), .we(we[1]), .data_out(data_out[1]),
    .resp_valid(resp_valid[1]), .resp_err(resp_err[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void sb_push(input int d, input exp_t e);
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endfunction

  function automatic int sb_size(input int d);
    return (d == 0) ? sb0.size() : sb1.size();
  endfunction

  function automatic exp_t sb_pop(input int d);
    if (d == 0) return sb0.pop_front();
    return sb1.pop_front();
  endfunction

  // Reference: a plain word array; the old word is returned, then lanes are merged.
  function automatic exp_t model_access(input int d, input logic [31:0] a,
                                        input logic [31:0] dat, input logic [3:0] w);
    exp_t e;
    int   idx;
    idx     = int'(a[TW+1:2]);
    e.err   = (a[1:0] != 2'b00);
    e.data  = 32'h0;
    e.known = 1'b1;
    e.cyc   = 0;
    if (!e.err) begin
      e.data  = mem_m[d][idx];
      e.known = known_m[d][idx];
      for (int i = 0; i < 4; i++)
        if (w[i]) mem_m[d][idx][8*i +: 8] = dat[8*i +: 8];
      if (w == 4'hF) known_m[d][idx] = 1'b1;
    end
    return e;
  endfunction

  function automatic void model_reset(input int d);
`ifdef DMEM_CLEAR_ON_RESET_EN
    for (int i = 0; i < NW; i++) begin
      mem_m[d][i]   = 32'h0;
      known_m[d][i] = 1'b1;
    end
`else
    if (d < 0) known_m[0][0] = 1'b0;
`endif
  endfunction

  task automatic issue(input int d, input logic [31:0] a, input logic [31:0] dat,
                       input logic [3:0] w, input bit track, input bit hold,
                       output int acc_cyc);
    int   budget;
    exp_t e;
    @(negedge clk);
    req[d]   = 1'b1;
    addr[d]  = a;
    wdata[d] = dat;
    we[d]    = w;
    budget   = 0;
    while (ready[d] !== 1'b1 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (ready[d] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout_d%0d: ready=%b after %0d cycles", d, ready[d], budget);
      req[d]  = 1'b0;
      acc_cyc = -1;
      return;
    end
    acc_cyc = cyc;
    if (track) begin
      e     = model_access(d, a, dat, w);
      e.cyc = cyc + 1 + lat_of(d);
      sb_push(d, e);
    end
    @(posedge clk);
    #1;
    if (!hold) req[d] = 1'b0;
  endtask

  task automatic release_reset(input int d);
    int cnt;
    @(posedge clk);
    #1;
    rst_n[d] = 1'b1;
    model_reset(d);
    cnt = 0;
    @(negedge clk);
    while (ready[d] !== 1'b1 && cnt < 5000) begin
      cnt++;
      @(negedge clk);
    end
    check($sformatf("ready_rise_d%0d", d), 32'(cnt), 32'(CLR_CYC));
  endtask

  // Monitor: pops one expectation per response pulse; also checks the following cycle.
  bit          prev_v [2];
  logic [31:0] prev_d [2];
  initial begin
    exp_t e;
    prev_v = '{0, 0};
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (prev_v[d]) begin
          check($sformatf("valid_drop_d%0d", d), {31'b0, resp_valid[d]}, 32'h0);
          check($sformatf("err_drop_d%0d", d), {31'b0, resp_err[d]}, 32'h0);
          check($sformatf("data_hold_d%0d", d), data_out[d], prev_d[d]);
          prev_v[d] = 1'b0;
        end
        if (resp_valid[d] === 1'b1) begin
          if (sb_size(d) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp_d%0d: got resp_valid=1 in cycle %0d, required none", d, cyc);
          end else begin
            e = sb_pop(d);
            check($sformatf("resp_cycle_d%0d", d), 32'(cyc), 32'(e.cyc));
            check($sformatf("resp_err_d%0d", d), {31'b0, resp_err[d]}, {31'b0, e.err});
            if (e.known) check($sformatf("resp_data_d%0d", d), data_out[d], e.data);
          end
          prev_v[d] = 1'b1;
          prev_d[d] = data_out[d];
        end
      end
    end
  end

  initial begin
    int          acc;
    int          acc_list [4];
    int          budget;
    logic [31:0] a;
    logic [3:0]  w;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0;
      req[d]   = 1'b0;
      addr[d]  = '0;
      wdata[d] = '0;
      we[d]    = '0;
      for (int i = 0; i < NW; i++) begin
        mem_m[d][i]   = 32'h0;
        known_m[d][i] = 1'b0;
      end
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_ready_d%0d", d), {31'b0, ready[d]}, 32'h0);
      check($sformatf("rst_valid_d%0d", d), {31'b0, resp_valid[d]}, 32'h0);
      check($sformatf("rst_err_d%0d", d), {31'b0, resp_err[d]}, 32'h0);
      check($sformatf("rst_data_d%0d", d), data_out[d], 32'h0);
    end
    release_reset(0);
    release_reset(1);

    // Preload every word so later loads have known contents.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NW; i++)
        issue(d, (32'(i) << 2) | ($urandom << (TW + 2)), $urandom, 4'hF, 1'b1, 1'b0, acc);

    // Directed sequence on the LAT=1 responder.
    issue(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, acc);
    issue(0, 32'h10, 32'h0,        4'h0, 1'b1, 1'b0, acc);
    issue(0, 32'h10, 32'h0000AB00, 4'b0010, 1'b1, 1'b0, acc);
    issue(0, 32'h10, 32'h0,        4'h0, 1'b1, 1'b0, acc);
    issue(0, 32'h13, 32'h0,        4'h0, 1'b1, 1'b0, acc);
    issue(0, 32'h10, 32'h0,        4'h0, 1'b1, 1'b0, acc);
    issue(0, 32'h21, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b0, acc);
    issue(0, 32'h20, 32'h0,        4'h0, 1'b1, 1'b0, acc);
    issue(0, 32'hFFFF_FF10, 32'h0, 4'h0, 1'b1, 1'b0, acc);

    // Back-to-back with req held on the LAT=3 responder; inputs change while busy.
    for (int k = 0; k < 4; k++) begin
      issue(1, 32'(k) << 2, 32'hA5A5_0000 | 32'(k), (k % 2 == 0) ? 4'hF : 4'h0,
            1'b1, (k != 3), acc);
      acc_list[k] = acc;
    end
    for (int k = 1; k < 4; k++)
      check($sformatf("accept_spacing_%0d", k), 32'(acc_list[k] - acc_list[k-1]), 32'd5);

    // Reset while the store waits: no response and no commit.
    issue(1, 32'h10, 32'h1234_5678, 4'hF, 1'b0, 1'b0, acc);
    @(negedge clk);
    rst_n[1] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("wait_rst_ready", {31'b0, ready[1]}, 32'h0);
    check("wait_rst_valid", {31'b0, resp_valid[1]}, 32'h0);
    release_reset(1);
    repeat (6) @(negedge clk);
    issue(1, 32'h10, 32'h0, 4'h0, 1'b1, 1'b0, acc);

    // Random traffic on both responders.
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 40; k++) begin
        a = $urandom;
        if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
        w = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        issue(d, a, $urandom, w, 1'b1, 1'($urandom_range(0, 1)), acc);
      end
      req[d] = 1'b0;
    end

    budget = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    repeat (2) @(negedge clk);
    check("sb_empty_d0", 32'(sb0.size()), 32'h0);
    check("sb_empty_d1", 32'(sb1.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
